mesm6_ifetch: RTL and testbench

//  Parametrised instruction prefetch queue for the MESM-6 core; replaces the single-word

---
 rtl/mesm6_ifetch.sv | 139 +++++++++++++
 tb/tb_mesm6_ifetch.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mesm6_ifetch.sv
// rtl/mesm6_ifetch.sv - MESM-6 instruction prefetch queue with half-word opcode output
// Optional zero-latency bypass from ibus_input when the queue is empty: MESM6_IFETCH_BYPASS_EN
`timescale 1ns/1ps
module mesm6_ifetch #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic              ibus_fetch,
    output logic [ADDR_W-1:0] ibus_addr,
    input  logic [47:0]       ibus_input,
    input  logic              ibus_done,
    input  logic              redirect,
    input  logic [ADDR_W:0]   redirect_pc,
    output logic              op_valid,
    output logic [23:0]       op,
    output logic [ADDR_W:0]   op_pc,
    input  logic              op_ready
);

    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, DISCARD} state_t;

    state_t            state_q;
    logic [PW:0]       rd_ptr_q, wr_ptr_q;
    logic [ADDR_W-1:0] fetch_addr_q, ibus_addr_q, head_addr_q;
    logic              h_q, started_q, ibus_fetch_q;
    logic [47:0]       mem_q [DEPTH];

    logic              empty, bypass_hit, consume, pop, push, full_next;
    logic [PW:0]       count, cnt_after;
    logic [47:0]       head_word, src_word;
    logic [ADDR_W-1:0] fetch_addr_inc, redirect_addr;

    assign empty          = (rd_ptr_q == wr_ptr_q);
    assign count          = wr_ptr_q - rd_ptr_q;
    assign head_word      = mem_q[rd_ptr_q[PW-1:0]];
    assign fetch_addr_inc = fetch_addr_q + 1'b1;
    assign redirect_addr  = redirect_pc[ADDR_W:1];

`ifdef MESM6_IFETCH_BYPASS_EN
    assign bypass_hit = empty && (state_q == FETCH) && !redirect && ibus_done;
`else
    assign bypass_hit = 1'b0;
`endif

    assign src_word = bypass_hit ? ibus_input : head_word;
    assign op_valid = !empty || bypass_hit;
    assign op       = op_valid ? (h_q ? src_word[23:0] : src_word[47:24]) : 24'h0;
    assign op_pc    = op_valid ? {head_addr_q, h_q} : '0;

    // A bypassed word whose second half is consumed at once never needs storing.
    assign consume   = op_valid && op_ready && !redirect;
    assign pop       = consume && h_q && !bypass_hit;
    assign push      = (state_q == FETCH) && ibus_done && !redirect
                       && !(bypass_hit && op_ready && h_q);
    assign cnt_after = count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    assign full_next = (cnt_after == (PW+1)'(DEPTH));

    assign ibus_fetch = ibus_fetch_q;
    assign ibus_addr  = ibus_addr_q;

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[PW-1:0]] <= ibus_input;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            fetch_addr_q <= '0;
            ibus_addr_q  <= '0;
            head_addr_q  <= '0;
            h_q          <= 1'b0;
            started_q    <= 1'b0;
            ibus_fetch_q <= 1'b0;
        end else begin
            if (consume) begin
                h_q <= !h_q;
                if (h_q) head_addr_q <= head_addr_q + 1'b1;
            end
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;

            if (redirect) begin
                rd_ptr_q     <= '0;
                wr_ptr_q     <= '0;
                h_q          <= redirect_pc[0];
                head_addr_q  <= redirect_addr;
                fetch_addr_q <= redirect_addr;
                started_q    <= 1'b1;
                // An open request cannot be withdrawn; wait out its response.
                if ((state_q != IDLE) && !ibus_done) begin
                    state_q <= DISCARD;
                end else begin
                    state_q      <= FETCH;
                    ibus_fetch_q <= 1'b1;
                    ibus_addr_q  <= redirect_addr;
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        if (started_q && !full_next) begin
                            state_q      <= FETCH;
                            ibus_fetch_q <= 1'b1;
                            ibus_addr_q  <= fetch_addr_q;
                        end
                    end
                    FETCH: begin
                        if (ibus_done) begin
                            fetch_addr_q <= fetch_addr_inc;
                            if (!full_next) begin
                                ibus_addr_q <= fetch_addr_inc;
                            end else begin
                                state_q      <= IDLE;
                                ibus_fetch_q <= 1'b0;
                            end
                        end
                    end
                    DISCARD: begin
                        if (ibus_done) begin
                            state_q      <= FETCH;
                            ibus_fetch_q <= 1'b1;
                            ibus_addr_q  <= fetch_addr_q;
                        end
                    end
                    default: begin
                        state_q      <= IDLE;
                        ibus_fetch_q <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mesm6_ifetch.sv
// tb/tb_mesm6_ifetch.sv - self-checking bench for mesm6_ifetch: vector table, corner sequences, random run
`timescale 1ns/1ps
module tb_mesm6_ifetch;

    localparam int AW    = 15;
    localparam int DEPTH = 4;

`ifdef MESM6_IFETCH_BYPASS_EN
    localparam logic EXP_BYP = 1'b1;
`else
    localparam logic EXP_BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic          ibus_fetch;
    logic [AW-1:0] ibus_addr;
    logic [47:0]   ibus_input;
    logic          ibus_done;
    logic          redirect;
    logic [AW:0]   redirect_pc;
    logic          op_valid;
    logic [23:0]   op;
    logic [AW:0]   op_pc;
    logic          op_ready;

    always #5 clk = ~clk;

    mesm6_ifetch #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk(clk), .reset_n(reset_n),
        .ibus_fetch(ibus_fetch), .ibus_addr(ibus_addr),
        .ibus_input(ibus_input), .ibus_done(ibus_done),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .op_valid(op_valid), .op(op), .op_pc(op_pc), .op_ready(op_ready)
    );

    typedef struct {
        logic [AW:0]   rpc;
        int            lat;
        logic [AW-1:0] a0, a1;
        logic [23:0]   o0, o1;
        logic [AW:0]   p0, p1;
    } vec_t;

    vec_t vecs[5];

    int checks = 0;
    int errors = 0;

    int            ready_mode, lat_fixed, cur_lat, resp_cnt, stall, total_cons;
    bit            lat_rand, live_chk, watch_done, redir_req;
    bit            prev_fetch, prev_done;
    logic [AW-1:0] prev_addr;
    logic [AW:0]   redir_val, exp_pc;
    logic          done_opv;
    logic [AW-1:0] fetch_q[$];
    logic [AW:0]   cons_pc_q[$];
    logic [23:0]   cons_op_q[$];

    // Memory image: two fixed words at 8/9, otherwise halves tagged with the address.
    function automatic logic [47:0] word_of(logic [AW-1:0] a);
        if (a == 15'h0008) return 48'hAAAAAA_BBBBBB;
        if (a == 15'h0009) return 48'hCCCCCC_DDDDDD;
        return {9'h150, a, 9'h0AB, a};
    endfunction

    function automatic logic [23:0] op_of(logic [AW:0] pc);
        logic [47:0] w;
        w = word_of(pc[AW:1]);
        return pc[0] ? w[23:0] : w[47:24];
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired, required event not seen", name);
    endtask

    task automatic step();
        bit new_req;
        @(negedge clk);
        new_req = ibus_fetch && (!prev_fetch || prev_done);
        if (new_req) begin
            fetch_q.push_back(ibus_addr);
            cur_lat  = lat_rand ? $urandom_range(0, 3) : lat_fixed;
            resp_cnt = 0;
        end
        if (prev_fetch && !prev_done) begin
            check("req_held", ibus_fetch, 1);
            check("addr_stable", ibus_addr, prev_addr);
        end
        if (ibus_fetch && resp_cnt >= cur_lat) begin
            ibus_done  = 1'b1;
            ibus_input = word_of(ibus_addr);
        end else begin
            ibus_done  = 1'b0;
            ibus_input = {16'($urandom), $urandom};
            if (ibus_fetch) resp_cnt++;
        end
        redirect    = redir_req;
        redirect_pc = redir_val;
        redir_req   = 1'b0;
        case (ready_mode)
            0:       op_ready = 1'b0;
            1:       op_ready = 1'b1;
            default: op_ready = 1'($urandom_range(0, 1));
        endcase
        #1;
        if (op_valid && op_ready && !redirect) begin
            check("op_pc", op_pc, exp_pc);
            check("op", op, op_of(exp_pc));
            cons_pc_q.push_back(op_pc);
            cons_op_q.push_back(op);
            exp_pc = exp_pc + 1'b1;
            stall  = 0;
            total_cons++;
        end else if (live_chk) begin
            stall++;
            if (stall > 60) begin
                fail_now("liveness");
                stall = 0;
            end
        end
        if (redirect) begin
            exp_pc = redirect_pc;
            fetch_q.delete();
            cons_pc_q.delete();
            cons_op_q.delete();
            stall = 0;
        end
        if (watch_done && ibus_done) begin
            done_opv   = op_valid;
            watch_done = 1'b0;
        end
        prev_fetch = ibus_fetch;
        prev_done  = ibus_done;
        prev_addr  = ibus_addr;
    endtask

    task automatic do_redirect(logic [AW:0] pc);
        redir_req = 1'b1;
        redir_val = pc;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation ran past its time limit");
        $fatal(1, "timeout");
    end

    initial begin
        bit found;
        vecs[0] = '{16'h0010, 1, 15'h0008, 15'h0009, 24'hAAAAAA, 24'hBBBBBB, 16'h0010, 16'h0011};
        vecs[1] = '{16'h0021, 1, 15'h0010, 15'h0011, 24'h558010, 24'hA80011, 16'h0021, 16'h0022};
        vecs[2] = '{16'h0100, 2, 15'h0080, 15'h0081, 24'hA80080, 24'h558080, 16'h0100, 16'h0101};
        vecs[3] = '{16'hFFFF, 0, 15'h7FFF, 15'h0000, 24'h55FFFF, 24'hA80000, 16'hFFFF, 16'h0000};
        vecs[4] = '{16'h0011, 3, 15'h0008, 15'h0009, 24'hBBBBBB, 24'hCCCCCC, 16'h0011, 16'h0012};

        reset_n = 1'b0; ibus_input = '0; ibus_done = 1'b0;
        redirect = 1'b0; redirect_pc = '0; op_ready = 1'b0;
        ready_mode = 0; lat_fixed = 1; cur_lat = 1; resp_cnt = 0; stall = 0; total_cons = 0;
        lat_rand = 1'b0; live_chk = 1'b0; watch_done = 1'b0; redir_req = 1'b0; redir_val = '0;
        prev_fetch = 1'b0; prev_done = 1'b0; prev_addr = '0; exp_pc = '0; done_opv = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_fetch", ibus_fetch, 0);
        check("rst_addr", ibus_addr, 0);
        check("rst_valid", op_valid, 0);
        check("rst_op", op, 0);
        check("rst_pc", op_pc, 0);
        reset_n = 1'b1;
        ready_mode = 1;
        repeat (10) step();
        check("no_fetch_before_redirect", fetch_q.size(), 0);
        check("idle_valid", op_valid, 0);

        for (int i = 0; i < 5; i++) begin
            lat_fixed  = vecs[i].lat;
            watch_done = (i == 0);
            do_redirect(vecs[i].rpc);
            step();
            if (i == 0) check("opv_after_redirect", op_valid, 0);
            repeat (16) step();
            if (fetch_q.size() < 2 || cons_op_q.size() < 2) begin
                fail_now("vec_progress");
            end else begin
                check("vec_addr0", fetch_q[0], vecs[i].a0);
                check("vec_addr1", fetch_q[1], vecs[i].a1);
                check("vec_op0", cons_op_q[0], vecs[i].o0);
                check("vec_pc0", cons_pc_q[0], vecs[i].p0);
                check("vec_op1", cons_op_q[1], vecs[i].o1);
                check("vec_pc1", cons_pc_q[1], vecs[i].p1);
            end
            if (i == 0) check("done_cycle_valid", done_opv, EXP_BYP);
        end

        // Fill with the core stalled, then free one word.
        ready_mode = 0; lat_fixed = 1;
        do_redirect(16'h0010);
        repeat (30) step();
        check("fill_reqs", fetch_q.size(), DEPTH);
        check("fill_idle", ibus_fetch, 0);
        if (fetch_q.size() >= 4) check("fill_last_addr", fetch_q[3], 15'h000B);
        check("fill_valid", op_valid, 1);
        check("fill_pc", op_pc, 16'h0010);
        ready_mode = 1;
        step();
        step();
        check("refill_wait", ibus_fetch, 0);
        ready_mode = 0;
        step();
        check("refill_start", ibus_fetch, 1);
        check("refill_addr", ibus_addr, 15'h000C);

        // Redirect while the fetch of word 9 is still outstanding.
        lat_fixed = 3;
        do_redirect(16'h0010);
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            step();
            if (fetch_q.size() >= 2) found = 1'b1;
        end
        if (!found) begin
            fail_now("discard_setup");
        end else begin
            check("discard_open_addr", fetch_q[1], 15'h0009);
            lat_fixed = 1; ready_mode = 1;
            do_redirect(16'h0100);
            repeat (20) step();
            if (fetch_q.size() < 1 || cons_op_q.size() < 1) begin
                fail_now("discard_progress");
            end else begin
                check("discard_next_addr", fetch_q[0], 15'h0080);
                check("discard_first_pc", cons_pc_q[0], 16'h0100);
                check("discard_first_op", cons_op_q[0], 24'hA80080);
            end
        end

        // Asynchronous reset with three words queued and a fetch open.
        ready_mode = 0; lat_fixed = 1;
        do_redirect(16'h0010);
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            step();
            if (fetch_q.size() >= 4) found = 1'b1;
        end
        if (!found) fail_now("reset_setup");
        check("pre_reset_fetch", ibus_fetch, 1);
        reset_n = 1'b0;
        #1;
        check("async_rst_fetch", ibus_fetch, 0);
        check("async_rst_addr", ibus_addr, 0);
        check("async_rst_valid", op_valid, 0);
        check("async_rst_op", op, 0);
        check("async_rst_pc", op_pc, 0);
        @(negedge clk);
        reset_n = 1'b1;
        prev_fetch = 1'b0; prev_done = 1'b0;
        fetch_q.delete();
        ready_mode = 1;
        repeat (8) step();
        check("post_reset_idle", fetch_q.size(), 0);
        check("post_reset_valid", op_valid, 0);

        // Random traffic against the op-stream model.
        ready_mode = 2; lat_rand = 1'b1; live_chk = 1'b1;
        do_redirect(16'h0040);
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 49) == 0) begin
                redir_req = 1'b1;
                redir_val = ($urandom_range(0, 3) == 0) ? (16'hFFF0 | 16'($urandom_range(0, 15)))
                                                        : 16'($urandom);
            end
            step();
        end
        live_chk = 1'b0;
        check("random_progress", total_cons > 500, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
